// File: rtl/eq_i2s_pkg.sv
// Shared constants and sample type for the I2S transmitter.
// Slot numbering covers one stereo frame, left channel first.
package eq_i2s_pkg;

    localparam int DATA_W_DEF     = 24;
    localparam int SLOTS          = 2 * DATA_W_DEF;
    localparam int WS_RIGHT_FIRST = DATA_W_DEF - 1;
    localparam int WS_LEFT_FIRST  = SLOTS - 1;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] lft;
        logic [DATA_W_DEF-1:0] rght;
    } stereo_smpl_t;

endpackage

// File: rtl/i2s_xmtr_if.sv
// Stereo sample handshake into the transmitter's holding register.
interface i2s_xmtr_if
    import eq_i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] lft_in;
    logic [DATA_W-1:0] rght_in;
    logic              smpl_vld;
    logic              smpl_rdy;

    modport master (output lft_in, output rght_in, output smpl_vld, input smpl_rdy);
    modport slave  (input lft_in, input rght_in, input smpl_vld, output smpl_rdy);

endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider and slot sequencer; all ws changes land on sclk falling edges.
// o_fall is high in the cycle before the clk edge on which sclk falls.
module i2s_clk_gen
    import eq_i2s_pkg::*;
#(
    parameter int  SCLK_DIV = 32,
    parameter int  DATA_W   = DATA_W_DEF,
    localparam int SW       = $clog2(2 * DATA_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic          o_sclk,
    output logic          o_fall,
    output logic [SW-1:0] o_slot,
    output logic          o_ws
);

    localparam int CW   = $clog2(SCLK_DIV);
    localparam int LAST = 2 * DATA_W - 1;
    localparam int WS_R = DATA_W - 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [SW-1:0] r_slot;
    logic [SW-1:0] w_slot_nxt;
    logic          w_wrap;
    logic          r_sclk;
    logic          r_ws;

    always_comb begin
        w_wrap     = (r_cnt == CW'(SCLK_DIV - 1));
        w_cnt_nxt  = w_wrap ? '0 : r_cnt + CW'(1);
        w_slot_nxt = r_slot;
        if (w_wrap) begin
            w_slot_nxt = (r_slot == SW'(LAST)) ? '0 : r_slot + SW'(1);
        end
    end

    // sclk and ws are computed from next-state values so they stay glitch-free registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= SW'(LAST);
            r_sclk <= 1'b0;
            r_ws   <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_slot <= SW'(LAST);
            r_sclk <= 1'b0;
            r_ws   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_slot <= w_slot_nxt;
            r_sclk <= (w_cnt_nxt >= CW'(SCLK_DIV / 2));
            r_ws   <= (w_slot_nxt >= SW'(WS_R)) && (w_slot_nxt != SW'(LAST));
        end
    end

    assign o_sclk = r_sclk;
    assign o_fall = i_en && w_wrap;
    assign o_slot = r_slot;
    assign o_ws   = r_ws;

endmodule

// File: rtl/i2s_xmtr.sv
// I2S transmitter: one-deep sample holding register, 48-bit frame shifter,
// and repeat-last-frame underrun handling.
module i2s_xmtr
    import eq_i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SCLK_DIV = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    i2s_xmtr_if.slave       smpl,
    output logic            I2S_sclk,
    output logic            I2S_ws,
    output logic            I2S_data,
    output logic            underrun
);

    localparam int FW   = 2 * DATA_W;
    localparam int SW   = $clog2(FW);
    localparam int LAST = FW - 1;

    logic          w_fall;
    logic          w_load;
    logic          w_acc;
    logic [SW-1:0] w_slot;
    logic [FW-1:0] r_hold;
    logic [FW-1:0] r_last;
    logic [FW-1:0] r_shift;
    logic          r_full;
    logic          r_underrun;

    i2s_clk_gen #(
        .SCLK_DIV (SCLK_DIV),
        .DATA_W   (DATA_W)
    ) u_clk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (en),
        .o_sclk (I2S_sclk),
        .o_fall (w_fall),
        .o_slot (w_slot),
        .o_ws   (I2S_ws)
    );

    assign w_load        = w_fall && (w_slot == SW'(LAST));
    assign w_acc         = smpl.smpl_vld && !r_full;
    assign smpl.smpl_rdy = !r_full;
    assign I2S_data      = r_shift[FW-1];
    assign underrun      = r_underrun;

    // A sample arriving on the load edge lands in holding only; that frame repeats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_hold <= '0;
        end else if (w_load && r_full) begin
            r_full <= 1'b0;
        end else if (w_acc) begin
            r_full <= 1'b1;
            r_hold <= {smpl.lft_in, smpl.rght_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_last     <= '0;
            r_underrun <= 1'b0;
        end else if (!en) begin
            r_shift    <= '0;
            r_last     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load && !r_full;
            if (w_load) begin
                if (r_full) begin
                    r_shift <= r_hold;
                    r_last  <= r_hold;
                end else begin
                    r_shift <= r_last;
                end
            end else if (w_fall) begin
                r_shift <= {r_shift[FW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_xmtr.sv
// Directed bench for i2s_xmtr: an sclk-rising-edge receiver rebuilds frames,
// which are compared against the samples the bench supplied.
module tb_i2s_xmtr;
    import eq_i2s_pkg::*;

    localparam int DIV   = 32;
    localparam int FRAME = SLOTS * DIV;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic sclk;
    logic ws;
    logic sdata;
    logic urun;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ur_cnt = 0;
    int n0 = 0;
    int ur0 = 0;

    logic [47:0] rxq[$];
    int          rx_c[$];
    logic [47:0] mon_sr;
    logic        mon_pw;
    logic [47:0] pr[16];

    stereo_smpl_t fa5, fx, fy, fz, fw;

    i2s_xmtr_if #(.DATA_W(DATA_W_DEF)) sif ();

    i2s_xmtr #(.DATA_W(DATA_W_DEF), .SCLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .smpl     (sif),
        .I2S_sclk (sclk),
        .I2S_ws   (ws),
        .I2S_data (sdata),
        .underrun (urun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (urun === 1'b1) ur_cnt++;

    // Receiver: a ws 1->0 seen on a rising sclk marks the last (right LSB) bit of a frame
    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            mon_sr = '0;
            mon_pw = 1'b0;
        end else begin
            mon_sr = {mon_sr[46:0], sdata};
            if (!ws && mon_pw) begin
                rxq.push_back(mon_sr);
                rx_c.push_back(cyc);
            end
            mon_pw = ws;
        end
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic wait_rx(input int n, input int nf, input string tag);
        int k = 0;
        while (rxq.size() < n && k < nf * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 48'(rxq.size() >= n), 48'd1);
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (sif.smpl_rdy !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("rdy_wait", 48'(sif.smpl_rdy), 48'd1);
    endtask

    task automatic wait_off(input int off);
        int k = 0;
        while (((cyc + 1 - n0) % FRAME) != off && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic supply(input logic [47:0] f);
        sif.lft_in   = f[47:24];
        sif.rght_in  = f[23:0];
        sif.smpl_vld = 1'b1;
        @(negedge clk);
        sif.smpl_vld = 1'b0;
    endtask

    initial begin
        fa5 = '{lft: 24'hA5A5A5, rght: 24'h5A5A5A};
        fx  = '{lft: 24'h123456, rght: 24'hFEDCBA};
        fy  = '{lft: 24'h0F0F0F, rght: 24'h818181};
        fz  = '{lft: 24'h96C3F0, rght: 24'h0F3C69};
        fw  = '{lft: 24'hDEADBE, rght: 24'hEF0123};
        for (int i = 0; i < 16; i++) pr[i] = 48'({$urandom(), $urandom()});

        rst_n = 1'b0;
        en = 1'b0;
        sif.smpl_vld = 1'b0;
        sif.lft_in = '0;
        sif.rght_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 48'({sclk, ws, sdata, urun, sif.smpl_rdy}), 48'(5'b00001));

        // Preloaded sample, then enable: load on the 32nd edge after en sampled high
        rst_n = 1'b1;
        @(negedge clk);
        supply(48'(fa5));
        chk("preload_rdy", 48'(sif.smpl_rdy), 48'd0);
        en = 1'b1;
        repeat (DIV - 1) @(posedge clk);
        #1 chk("before_first_load", 48'({sdata, sif.smpl_rdy}), 48'(2'b00));
        @(posedge clk);
        #1 chk("first_load", 48'({sdata, ws, urun, sif.smpl_rdy}), 48'(4'b1001));
        n0 = cyc;
        repeat (23 * DIV - 1) @(posedge clk);
        #1 chk("ws_before_slot23", 48'(ws), 48'd0);
        @(posedge clk);
        #1 chk("ws_rise_slot23", 48'(ws), 48'd1);
        repeat (24 * DIV - 1) @(posedge clk);
        #1 chk("ws_before_slot47", 48'(ws), 48'd1);
        @(posedge clk);
        #1 chk("ws_fall_slot47", 48'(ws), 48'd0);
        repeat (DIV) @(posedge clk);
        #1 chk("underrun_pulse", 48'(urun), 48'd1);
        @(posedge clk);
        #1 chk("underrun_one_cycle", 48'(urun), 48'd0);
        @(negedge clk);
        wait_rx(2, 2, "rx_a5_wait");
        chk("frame_a5_0", rxq[0], 48'(fa5));
        chk("frame_a5_1", rxq[1], 48'(fa5));
        chk("frame_period", 48'(rx_c[1] - rx_c[0]), 48'(FRAME));

        // Streaming: a new pair one cycle after each rdy, no underrun
        rxq.delete();
        ur0 = ur_cnt;
        for (int i = 0; i < 16; i++) begin
            wait_rdy();
            @(negedge clk);
            supply(pr[i]);
        end
        wait_rdy();
        chk("stream_no_underrun", 48'(ur_cnt - ur0), 48'd0);
        wait_rx(16, 17, "rx_stream_wait");
        for (int i = 0; i < 16; i++) chk($sformatf("stream_frame%0d", i), rxq[i], pr[i]);

        // Starvation repeats the last pair, one underrun per frame; resume follows
        rxq.delete();
        ur0 = ur_cnt;
        wait_rx(2, 3, "rx_starve_wait");
        chk("starve_frame0", rxq[0], pr[15]);
        chk("starve_frame1", rxq[1], pr[15]);
        chk("starve_underruns", 48'(ur_cnt - ur0), 48'd2);
        rxq.delete();
        ur0 = ur_cnt;
        repeat (100) @(negedge clk);
        supply(48'(fx));
        wait_rx(2, 3, "rx_resume_wait");
        chk("resume_cur_frame", rxq[0], pr[15]);
        chk("resume_x_frame", rxq[1], 48'(fx));
        chk("resume_underruns", 48'(ur_cnt - ur0), 48'd1);

        // Sample offered exactly on the load edge with holding empty
        wait_off(0);
        sif.lft_in = fy.lft;
        sif.rght_in = fy.rght;
        sif.smpl_vld = 1'b1;
        @(posedge clk);
        #1 chk("edge_underrun", 48'(urun), 48'd1);
        chk("edge_held", 48'(sif.smpl_rdy), 48'd0);
        @(negedge clk);
        sif.smpl_vld = 1'b0;
        rxq.delete();
        wait_rx(2, 3, "rx_edge_wait");
        chk("edge_repeat_x", rxq[0], 48'(fx));
        chk("edge_then_y", rxq[1], 48'(fy));

        // Enable dropped in slot 10 with a sample held
        wait_off(100);
        supply(48'(fz));
        wait_off(10 * DIV + 20);
        chk("pre_drop_sclk", 48'(sclk), 48'd1);
        en = 1'b0;
        @(posedge clk);
        #1 chk("drop_outs", 48'({sclk, ws, sdata, urun}), 48'd0);
        chk("drop_hold_kept", 48'(sif.smpl_rdy), 48'd0);
        repeat (40) @(negedge clk);
        chk("idle_outs", 48'({sclk, ws, sdata, urun, sif.smpl_rdy}), 48'd0);
        rxq.delete();
        en = 1'b1;
        repeat (DIV - 1) @(posedge clk);
        #1 chk("reen_before_load", 48'(sdata), 48'd0);
        @(posedge clk);
        #1 chk("reen_load", 48'({sdata, urun, sif.smpl_rdy}), 48'(3'b101));
        n0 = cyc;
        @(negedge clk);
        wait_rx(1, 2, "rx_reen_wait");
        chk("reen_frame_z", rxq[0], 48'(fz));

        // Asynchronous reset mid-frame with a stale sample in holding
        wait_off(50);
        supply(48'(fw));
        wait_off(6 * DIV + 21);
        chk("pre_rst_sclk", 48'(sclk), 48'd1);
        rst_n = 1'b0;
        #1 chk("async_rst_outs", 48'({sclk, ws, sdata, urun, sif.smpl_rdy}), 48'(5'b00001));
        repeat (3) @(negedge clk);
        rxq.delete();
        rst_n = 1'b1;
        repeat (DIV) @(posedge clk);
        #1 chk("post_rst_load", 48'({sdata, urun, sif.smpl_rdy}), 48'(3'b011));
        @(negedge clk);
        wait_rx(1, 2, "rx_post_rst_wait");
        chk("post_rst_frame", rxq[0], 48'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
